counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencer and controller for a synchronous mod-N up counter.
- A host issues start/stop/pause and a programmed modulus and lap count; the block runs the counter, flags every wrap, counts laps, and pulses done after the programmed number of laps.
- Sits between control logic and the counter datapath, replacing free-running counters where bounded, restartable counting is required.

Parameters:
- CW, 4, counter width in bits.
- LW, 8, lap counter and cfg_laps width in bits.
- DEF_LAST, 7, terminal count used when cfg_last = 0 (default mod-8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- start  in  1  level; sampled in IDLE only.
- stop  in  1  level; abort run.
- pause  in  1  level; hold count while high.
- cfg_last  in  CW  terminal count (modulus-1); 0 selects DEF_LAST.
- cfg_laps  in  LW  laps to run; 0 = free-run.
- count  out  CW  current count.
- wrap  out  1  one-cycle pulse on terminal-count rollover.
- laps_done  out  LW  completed laps, saturating.
- busy  out  1  high in RUN and PAUSE.
- done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (rst=0, async): state IDLE, count=0, wrap=0, laps_done=0, busy=0, done=0, captured config cleared.
- All outputs are registered.
- States:
  - IDLE
  - RUN
  - PAUSE
  - DONE
- IDLE:
  - Outputs hold their last values, except wrap=0 and done=0.
  - start=1 at an edge: go to RUN, count=0, laps_done=0, busy=1.
  - On the same edge, capture cfg_last (0 -> DEF_LAST) and cfg_laps into internal registers.
  - Config changes while busy are ignored.
- RUN, per edge, in priority order:
  - stop=1: go to IDLE, count and laps_done frozen, busy=0, no wrap, no done.
  - pause=1: go to PAUSE, count held.
  - count == last: count=0, wrap=1, laps_done+1 (saturate at 2^LW-1).
    - If laps != 0 and the new laps_done == laps: go to DONE, done=1, busy=0.
  - Otherwise: count+1.
- First increment: on the edge after RUN is entered. Counting latency from start is 1 edge to reach count=0, then 1 edge per step.
- PAUSE:
  - stop=1: go to IDLE (as in RUN).
  - pause=0: go to RUN, count held on that edge; increments resume on the following edge.
- DONE:
  - Lasts exactly one cycle, with done=1 and count=0.
  - Then go to IDLE, done=0.
  - start during DONE is ignored.
- Simultaneous events:
  - start+stop in IDLE: start wins.
  - stop+pause or stop+terminal count in RUN: stop wins, no wrap.
- wrap is high only on the edge where count returns to 0 from last; it is never high in IDLE or PAUSE.
- Free-run (laps=0): never reaches DONE; laps_done saturates at 2^LW-1 and wrap continues.
- Reset mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Shared package counter_pkg:
  - State encoding localparams (IDLE=0, RUN=1, PAUSE=2, DONE=3).
  - DEF_LAST default.
  - Saturating-increment function.
- Sub-module mod_n_counter: the count register with en, clr, last inputs and a wrap output.
- The FSM, lap counter and config capture stay in counter_seq_ctrl.

Test Plan:
- Reset value check: hold rst=0 mid-count (after any run) -> all outputs 0 immediately, state IDLE; release, no activity until start.
- Mod-8, 2 laps: cfg_last=0, cfg_laps=2, start for 1 cycle.
  - Edges E1..E7 give count 1..7.
  - E8: count=0, wrap=1, laps_done=1.
  - E16: wrap=1, laps_done=2, done=1.
  - E17: done=0, busy=0.
- Mod-5 free-run: cfg_last=4, cfg_laps=0 -> count cycles 0,1,2,3,4,0 with wrap every 5 edges; done never asserts over 300 edges (laps_done saturates at 255 after 1275 edges in a longer run).
- Pause: mod-8, pause=1 at count=3 for 4 cycles -> count stays 3 throughout; after pause falls, count=3 for one more edge, then 4; total edges to done increase by 5.
- Stop: stop=1 with count=6 in lap 1 -> IDLE, count=6 and laps_done=0 frozen, no done; stop and terminal count together at count=7 -> count stays 7, no wrap.
- Restart and config isolation: change cfg_last from 7 to 2 while busy -> still mod-8; start asserted during DONE is ignored; a new start in IDLE applies mod-3 and clears laps_done.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types, constants and helpers for the counter sequencer.
package counter_pkg;

  // Controller state encoding.
  localparam logic [1:0] StateIdle  = 2'd0;
  localparam logic [1:0] StateRun   = 2'd1;
  localparam logic [1:0] StatePause = 2'd2;
  localparam logic [1:0] StateDone  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = StateIdle,
    StRun   = StateRun,
    StPause = StatePause,
    StDone  = StateDone
  } state_e;

  // Terminal count used when the host programs cfg_last = 0 (mod-8).
  localparam int unsigned DefLast = 7;

  // Increment that sticks at max instead of rolling over.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Mod-N up counter: counts 0..last, clears on clr, flags the rollover edge.
module mod_n_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] last,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear wins over enable; roll to 0 after last.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == last) ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // High when the coming edge takes the count from last back to 0.
  assign wrap  = en && !clr && (count_q == last);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run controller for a mod-N counter: start/stop/pause, lap counting, done pulse.
module counter_seq_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned CW       = 4,
  parameter int unsigned LW       = 8,
  parameter int unsigned DEF_LAST = DefLast
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic [CW-1:0] cfg_last,
  input  logic [LW-1:0] cfg_laps,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic [LW-1:0] laps_done,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] DefLastW = CW'(DEF_LAST);
  localparam logic [31:0]   LapsMax  = 32'((64'd1 << LW) - 64'd1);

  state_e        state_q, state_d;
  logic [CW-1:0] last_q, last_d;
  logic [LW-1:0] goal_q, goal_d;
  logic [LW-1:0] laps_q, laps_d;
  logic          wrap_q, wrap_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          cnt_en, cnt_clr, cnt_wrap;
  logic [31:0]   laps_inc32;
  logic [LW-1:0] laps_inc;
  logic          unused_laps_hi;

  assign laps_inc32     = sat_inc(32'(laps_q), LapsMax);
  assign laps_inc       = laps_inc32[LW-1:0];
  assign unused_laps_hi = ^laps_inc32;

  mod_n_counter #(
    .CW (CW)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .last  (last_q),
    .count (count),
    .wrap  (cnt_wrap)
  );

  // Next state, config capture, lap count and registered pulse outputs.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    goal_d  = goal_q;
    laps_d  = laps_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        // start beats a simultaneous stop
        if (start) begin
          state_d = StRun;
          cnt_clr = 1'b1;
          laps_d  = '0;
          busy_d  = 1'b1;
          last_d  = (cfg_last == '0) ? DefLastW : cfg_last;
          goal_d  = cfg_laps;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (pause) begin
          state_d = StPause;
        end else begin
          cnt_en = 1'b1;
          if (cnt_wrap) begin
            wrap_d = 1'b1;
            laps_d = laps_inc;
            if (goal_q != '0 && laps_inc == goal_q) begin
              state_d = StDone;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end
      StPause: begin
        if (stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (!pause) begin
          // count is held on the resume edge
          state_d = StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= '0;
      goal_q  <= '0;
      laps_q  <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      goal_q  <= goal_d;
      laps_q  <= laps_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wrap      = wrap_q;
  assign laps_done = laps_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: directed scenarios plus random vs model.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [3:0] cfg_last = '0;
  logic [7:0] cfg_laps = '0;
  logic [3:0] count;
  logic       wrap, busy, done;
  logic [7:0] laps_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: run flags plus modulo arithmetic.
  int m_count, m_laps, m_last, m_goal;
  bit m_busy, m_paused, m_done_cyc, m_wrap, m_done;

  logic [14:0] obs, exp_v;
  assign obs = {count, wrap, laps_done, busy, done};

  counter_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .cfg_last  (cfg_last),
    .cfg_laps  (cfg_laps),
    .count     (count),
    .wrap      (wrap),
    .laps_done (laps_done),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_count = 0; m_laps = 0; m_last = 0; m_goal = 0;
    m_busy = 0; m_paused = 0; m_done_cyc = 0; m_wrap = 0; m_done = 0;
  endtask

  // Predict outputs after the coming edge from the current inputs.
  task automatic model_edge();
    m_wrap = 0;
    m_done = 0;
    if (m_done_cyc) begin
      m_done_cyc = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_paused = 0; m_count = 0; m_laps = 0;
        m_last = (cfg_last == 0) ? 7 : int'(cfg_last);
        m_goal = int'(cfg_laps);
      end
    end else if (stop) begin
      m_busy = 0;
    end else if (m_paused) begin
      if (!pause) m_paused = 0;
    end else if (pause) begin
      m_paused = 1;
    end else begin
      m_count = (m_count + 1) % (m_last + 1);
      if (m_count == 0) begin
        m_wrap = 1;
        if (m_laps < 255) m_laps++;
        if (m_goal != 0 && m_laps == m_goal) begin
          m_done = 1; m_busy = 0; m_done_cyc = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) $display("FAIL reset_initial: got %h want %h", obs, exp_v);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (obs !== exp_v) $display("FAIL reset_idle_quiet[%0d]: got %h want %h", i, obs, exp_v);
      else n_pass++;
    end
    // Run a while, then assert reset between edges.
    cfg_last = 4'd0; cfg_laps = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== exp_v) $display("FAIL reset_async: got %h want %h", obs, exp_v);
    else n_pass++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (obs !== exp_v) $display("FAIL reset_release[%0d]: got %h want %h", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_mod8_two_laps();
    cfg_last = 4'd0; cfg_laps = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    exp_v = {4'd0, 1'b0, 8'd0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL mod8_start: got %h want %h", obs, exp_v);
    else n_pass++;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e <= 16)
        exp_v = {4'(e % 8), 1'(e % 8 == 0), 8'(e / 8), 1'(e < 16), 1'(e == 16)};
      else
        exp_v = {4'd0, 1'b0, 8'd2, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) $display("FAIL mod8_edge%0d: got %h want %h", e, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_free_run();
    cfg_last = 4'd4; cfg_laps = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 1300; e++) begin
      step();
      exp_v = {4'(e % 5), 1'(e % 5 == 0), 8'((e / 5 > 255) ? 255 : e / 5), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) $display("FAIL freerun_edge%0d: got %h want %h", e, obs, exp_v);
      else n_pass++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    exp_v = {4'd0, 1'b0, 8'd255, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL freerun_stop: got %h want %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_pause();
    int c;
    cfg_last = 4'd7; cfg_laps = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      pause = (e >= 4 && e <= 7);
      step();
      if (e <= 3)       c = e;
      else if (e <= 8)  c = 3;
      else if (e <= 12) c = e - 5;
      else              c = 0;
      exp_v = {4'(c), 1'(e == 13), 8'(e >= 13), 1'(e < 13), 1'(e == 13)};
      n_checks++;
      if (obs !== exp_v) $display("FAIL pause_edge%0d: got %h want %h", e, obs, exp_v);
      else n_pass++;
    end
    pause = 1'b0;
  endtask

  task automatic test_stop();
    cfg_last = 4'd0; cfg_laps = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    exp_v = {4'd6, 1'b0, 8'd0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs !== exp_v) $display("FAIL stop_frozen[%0d]: got %h want %h", i, obs, exp_v);
      else n_pass++;
      step();
    end
    // start and stop together in idle: start wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    exp_v = {4'd0, 1'b0, 8'd0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL stop_start_wins: got %h want %h", obs, exp_v);
    else n_pass++;
    for (int i = 0; i < 7; i++) step();
    exp_v = {4'd7, 1'b0, 8'd0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL stop_at7_pre: got %h want %h", obs, exp_v);
    else n_pass++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    exp_v = {4'd7, 1'b0, 8'd0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL stop_at_terminal: got %h want %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_config_isolation();
    cfg_last = 4'd7; cfg_laps = 8'd1; start = 1'b1;
    step();
    start = 1'b0; cfg_last = 4'd2; cfg_laps = 8'd5;
    for (int e = 1; e <= 13; e++) begin
      if (e == 9 || e == 10) start = 1'b1;
      else start = 1'b0;
      step();
      if (e <= 8)       exp_v = {4'(e % 8), 1'(e == 8), 8'(e == 8), 1'(e < 8), 1'(e == 8)};
      else if (e == 9)  exp_v = {4'd0, 1'b0, 8'd1, 1'b0, 1'b0};
      else if (e == 10) exp_v = {4'd0, 1'b0, 8'd0, 1'b1, 1'b0};
      else              exp_v = {4'((e - 10) % 3), 1'(e == 13), 8'(e == 13), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) $display("FAIL cfg_iso_edge%0d: got %h want %h", e, obs, exp_v);
      else n_pass++;
    end
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_random();
    #3 rst = 1'b0;
    step();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      cfg_last = 4'($urandom_range(0, 15));
      cfg_laps = 8'($urandom_range(0, 3));
      model_edge();
      step();
      exp_v = {4'(m_count), m_wrap, 8'(m_laps), m_busy, m_done};
      n_checks++;
      if (obs !== exp_v) $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_v);
      else n_pass++;
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_mod8_two_laps();
    test_free_run();
    test_pause();
    test_stop();
    test_config_isolation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
